// File: rtl/des_perm_pipe.sv
// Pipelined DES bit-permutation unit: pass / IP / FP / half-swap+FP per beat,
// with a bubble-collapsing valid/ready register chain carrying a sideband tag.
module des_perm_pipe #(
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_mode,
   input  logic [63:0]      in_block,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [63:0]      out_block,
   output logic [TAG_W-1:0] out_tag,
   output logic [2:0]       occupancy
);

   typedef enum logic [1:0] {
      MODE_PASS    = 2'b00,
      MODE_IP      = 2'b01,
      MODE_FP      = 2'b10,
      MODE_SWAP_FP = 2'b11
   } mode_e;

   // Final permutation source indices: out[i] = in[FP_TAB[i]].
   localparam logic [5:0] FP_TAB [64] = '{
      6'd39, 6'd7, 6'd47, 6'd15, 6'd55, 6'd23, 6'd63, 6'd31,
      6'd38, 6'd6, 6'd46, 6'd14, 6'd54, 6'd22, 6'd62, 6'd30,
      6'd37, 6'd5, 6'd45, 6'd13, 6'd53, 6'd21, 6'd61, 6'd29,
      6'd36, 6'd4, 6'd44, 6'd12, 6'd52, 6'd20, 6'd60, 6'd28,
      6'd35, 6'd3, 6'd43, 6'd11, 6'd51, 6'd19, 6'd59, 6'd27,
      6'd34, 6'd2, 6'd42, 6'd10, 6'd50, 6'd18, 6'd58, 6'd26,
      6'd33, 6'd1, 6'd41, 6'd9,  6'd49, 6'd17, 6'd57, 6'd25,
      6'd32, 6'd0, 6'd40, 6'd8,  6'd48, 6'd16, 6'd56, 6'd24
   };

   function automatic logic [63:0] perm_fp(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = x[FP_TAB[i]];
      return r;
   endfunction

   function automatic logic [63:0] perm_ip(input logic [63:0] x);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[FP_TAB[i]] = x[i];
      return r;
   endfunction

   mode_e                  mode;
   logic [63:0]            perm_block;
   logic [PIPE_STAGES-1:0] load;
   logic                   accept;
   logic                   emit;

   logic [PIPE_STAGES-1:0] valid_q, valid_d;
   logic [63:0]            block_q [PIPE_STAGES];
   logic [63:0]            block_d [PIPE_STAGES];
   logic [TAG_W-1:0]       tag_q   [PIPE_STAGES];
   logic [TAG_W-1:0]       tag_d   [PIPE_STAGES];
   logic [2:0]             occ_q, occ_d;

   assign mode = mode_e'(in_mode);

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      perm_block = in_block;
      case (mode)
         MODE_PASS:    perm_block = in_block;
         MODE_IP:      perm_block = perm_ip(in_block);
         MODE_FP:      perm_block = perm_fp(in_block);
         MODE_SWAP_FP: perm_block = perm_fp({in_block[31:0], in_block[63:32]});
         default:      perm_block = in_block;
      endcase
   end

   // A stage may load when empty or when its contents move on this cycle.
   always_comb begin
      load = '0;
      load[PIPE_STAGES-1] = !valid_q[PIPE_STAGES-1] || out_ready;
      for (int k = PIPE_STAGES - 2; k >= 0; k--) load[k] = !valid_q[k] || load[k+1];
   end

   assign in_ready = reset_n && load[0];
   assign accept   = in_valid && in_ready;
   assign emit     = valid_q[PIPE_STAGES-1] && out_ready;

   always_comb begin
      valid_d = valid_q;
      block_d = block_q;
      tag_d   = tag_q;
      if (load[0]) valid_d[0] = accept;
      if (accept) begin
         block_d[0] = perm_block;
         tag_d[0]   = in_tag;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
         if (load[k]) begin
            valid_d[k] = valid_q[k-1];
            if (valid_q[k-1]) begin
               block_d[k] = block_q[k-1];
               tag_d[k]   = tag_q[k-1];
            end
         end
      end
   end

   always_comb begin
      occ_d = occ_q;
      if (accept && !emit)      occ_d = occ_q + 3'd1;
      else if (emit && !accept) occ_d = occ_q - 3'd1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
         valid_q <= '0;
         occ_q   <= '0;
         // NOTE: datapath registers are cleared too, since out_block/out_tag must read zero after reset.
         for (int k = 0; k < PIPE_STAGES; k++) begin
            block_q[k] <= '0;
            tag_q[k]   <= '0;
         end
      end else begin
         valid_q <= valid_d;
         block_q <= block_d;
         tag_q   <= tag_d;
         occ_q   <= occ_d;
      end
   end

   assign out_valid = valid_q[PIPE_STAGES-1];
   assign out_block = block_q[PIPE_STAGES-1];
   assign out_tag   = tag_q[PIPE_STAGES-1];
   assign occupancy = occ_q;

endmodule

// File: tb/tb_des_perm_pipe.sv
// Scoreboard bench for des_perm_pipe: randomized beats against a reference permutation
// model, plus reset / latency checks on PIPE_STAGES = 1, 2 and 4 instances.
module tb_des_perm_pipe;
   localparam int PS = 2;
   localparam int TW = 4;

   typedef struct packed {
      logic [63:0]    blk;
      logic [TW-1:0]  tag;
   } beat_t;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          in_valid, in_ready;
   logic [1:0]    in_mode;
   logic [63:0]   in_block;
   logic [TW-1:0] in_tag;
   logic          out_valid, out_ready;
   logic [63:0]   out_block;
   logic [TW-1:0] out_tag;
   logic [2:0]    occupancy;

   logic          xrst;
   logic [1:0]    x_mode;
   logic          x_in_valid  [3];
   logic          x_in_ready  [3];
   logic          x_out_valid [3];
   logic          x_out_ready [3];
   logic [63:0]   x_in_block  [3];
   logic [63:0]   x_out_block [3];
   logic [TW-1:0] x_in_tag    [3];
   logic [TW-1:0] x_out_tag   [3];
   logic [2:0]    x_occ       [3];

   int            checks = 0;
   int            errors = 0;
   int            n_acc = 0;
   int            n_emit = 0;
   int            max_occ = 0;
   bit            mon_en = 1'b0;
   bit            holding = 1'b0;
   logic [63:0]   hold_blk;
   logic [TW-1:0] hold_tag;
   beat_t         exp_q [$];
   logic [63:0]   cap_q [$];

   logic [63:0]   orig [8];
   logic [TW-1:0] tg   [8];
   logic [1:0]    md4  [8];
   int            b4;
   bit            ordy;
   bit            acc;
   int            lat;

   always #5 clk = ~clk;

   des_perm_pipe #(.PIPE_STAGES(PS), .TAG_W(TW)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_block(in_block), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_block(out_block), .out_tag(out_tag), .occupancy(occupancy)
   );

   for (genvar g = 0; g < 3; g++) begin : g_x
      des_perm_pipe #(.PIPE_STAGES(g == 0 ? 1 : (g == 1 ? 2 : 4)), .TAG_W(TW)) u_x (
         .clk(clk), .reset_n(xrst),
         .in_valid(x_in_valid[g]), .in_ready(x_in_ready[g]), .in_mode(x_mode),
         .in_block(x_in_block[g]), .in_tag(x_in_tag[g]),
         .out_valid(x_out_valid[g]), .out_ready(x_out_ready[g]),
         .out_block(x_out_block[g]), .out_tag(x_out_tag[g]), .occupancy(x_occ[g])
      );
   end

   // Row a of the FP table holds base[b] - a, base = 39,7,47,15,55,23,63,31.
   function automatic int fp_src(input int i);
      return (((i % 8) % 2 == 1) ? 7 : 39) + 8 * ((i % 8) / 2) - i / 8;
   endfunction

   function automatic logic [63:0] fp_model(input logic [63:0] x);
      logic [63:0] r;
      logic [5:0]  k;
      for (int i = 0; i < 64; i++) begin
         k = 6'(fp_src(i));
         r[i] = x[k];
      end
      return r;
   endfunction

   function automatic logic [63:0] ip_model(input logic [63:0] x);
      logic [63:0] r;
      logic [5:0]  k;
      for (int i = 0; i < 64; i++) begin
         k = 6'(fp_src(i));
         r[k] = x[i];
      end
      return r;
   endfunction

   function automatic logic [63:0] model(input logic [1:0] m, input logic [63:0] x);
      case (m)
         2'b01:   return ip_model(x);
         2'b10:   return fp_model(x);
         2'b11:   return fp_model({x[31:0], x[63:32]});
         default: return x;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Monitor: the handshake seen at a negedge completes at the following posedge.
   always @(negedge clk) begin
      if (mon_en) begin
         beat_t e;
         check("occupancy", 64'(occupancy), 64'(exp_q.size()));
         if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
         if (holding && out_valid) begin
            check("hold_block", out_block, hold_blk);
            check("hold_tag", 64'(out_tag), 64'(hold_tag));
         end
         holding  = out_valid && !out_ready;
         hold_blk = out_block;
         hold_tag = out_tag;
         if (out_valid && out_ready) begin
            n_emit++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat got=%h", out_block);
            end else begin
               e = exp_q.pop_front();
               check("out_block", out_block, e.blk);
               check("out_tag", 64'(out_tag), 64'(e.tag));
               cap_q.push_back(out_block);
            end
         end
      end
   end

   task automatic drive(input bit v, input logic [1:0] m, input logic [63:0] b, input logic [63:0] expb,
                        input logic [TW-1:0] t, input bit rdy, output bit accd);
      beat_t e;
      in_valid  = v;
      in_mode   = m;
      in_block  = b;
      in_tag    = t;
      out_ready = rdy;
      @(negedge clk);
      accd = v && in_ready;
      @(posedge clk);
      #1;
      if (accd) begin
         e.blk = expb;
         e.tag = t;
         exp_q.push_back(e);
         n_acc++;
      end
      in_valid = 1'b0;
   endtask

   task automatic send_beat(input logic [1:0] m, input logic [63:0] b, input logic [63:0] expb,
                            input logic [TW-1:0] t, input bit rnd_ready);
      bit a;
      int tries;
      a = 1'b0;
      tries = 0;
      while (!a && tries < 64) begin
         drive(1'b1, m, b, expb, t, rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1, a);
         tries++;
      end
      if (!a) begin
         checks++;
         errors++;
         $display("FAIL send_timeout got=not_accepted exp=accepted");
      end
   endtask

   task automatic drain();
      bit a;
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         drive(1'b0, 2'b00, 64'h0, 64'h0, '0, 1'b1, a);
         n++;
      end
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic directed(input logic [1:0] m, input logic [63:0] b, input logic [63:0] expb);
      bit a;
      int l;
      send_beat(m, b, expb, 4'hA, 1'b0);
      l = 0;
      while (!out_valid && l < 20) begin
         drive(1'b0, 2'b00, 64'h0, 64'h0, '0, 1'b1, a);
         l++;
      end
      check("latency", 64'(l), 64'(PS - 1));
      drain();
   endtask

   task automatic reset_test(input int j, input int p);
      logic [63:0] blk;
      int          l;
      x_out_ready[j] = 1'b0;
      x_in_block[j]  = {$urandom, $urandom};
      x_in_tag[j]    = 4'h1;
      x_in_valid[j]  = 1'b1;
      @(posedge clk); #1;
      x_in_block[j]  = {$urandom, $urandom};
      x_in_tag[j]    = 4'h2;
      @(posedge clk); #1;
      x_in_valid[j]  = 1'b0;
      check("x_occ_before_rst", 64'(x_occ[j]), (p >= 2) ? 64'd2 : 64'd1);
      xrst = 1'b0;
      @(posedge clk); #1;
      check("x_rst_out_valid", 64'(x_out_valid[j]), 64'd0);
      check("x_rst_occ", 64'(x_occ[j]), 64'd0);
      check("x_rst_in_ready", 64'(x_in_ready[j]), 64'd0);
      check("x_rst_out_block", x_out_block[j], 64'd0);
      check("x_rst_out_tag", 64'(x_out_tag[j]), 64'd0);
      xrst = 1'b1;
      #1;
      check("x_in_ready_after_rst", 64'(x_in_ready[j]), 64'd1);
      blk = {$urandom, $urandom};
      x_out_ready[j] = 1'b1;
      x_in_block[j]  = blk;
      x_in_tag[j]    = 4'h5;
      x_in_valid[j]  = 1'b1;
      @(posedge clk); #1;
      x_in_valid[j]  = 1'b0;
      l = 0;
      while (!x_out_valid[j] && l < 10) begin
         @(posedge clk); #1;
         l++;
      end
      check("x_latency", 64'(l), 64'(p - 1));
      check("x_block", x_out_block[j], model(x_mode, blk));
      check("x_tag", 64'(x_out_tag[j]), 64'h5);
      @(posedge clk); #1;
      check("x_no_duplicate", 64'(x_out_valid[j]), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      reset_n   = 1'b0;
      xrst      = 1'b0;
      in_valid  = 1'b0;
      in_mode   = 2'b00;
      in_block  = '0;
      in_tag    = '0;
      out_ready = 1'b0;
      x_mode    = 2'b11;
      for (int j = 0; j < 3; j++) begin
         x_in_valid[j]  = 1'b0;
         x_out_ready[j] = 1'b0;
         x_in_block[j]  = '0;
         x_in_tag[j]    = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_out_block", out_block, 64'd0);
      check("rst_out_tag", 64'(out_tag), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      reset_n = 1'b1;
      xrst    = 1'b1;
      #1;
      check("in_ready_after_rst", 64'(in_ready), 64'd1);
      mon_en = 1'b1;

      // Known-answer beats with latency measured from the accept edge.
      directed(2'b10, 64'h1, 64'h0200_0000_0000_0000);
      directed(2'b01, 64'h1, 64'h0000_0080_0000_0000);
      directed(2'b11, 64'h1, 64'h0100_0000_0000_0000);
      directed(2'b00, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

      // IP round trip: the DUT's IP output fed back as an FP beat must return the original.
      for (int bt = 0; bt < 125; bt++) begin
         cap_q.delete();
         for (int i = 0; i < 8; i++) begin
            orig[i] = {$urandom, $urandom};
            tg[i]   = TW'($urandom);
            send_beat(2'b01, orig[i], ip_model(orig[i]), tg[i], 1'b1);
         end
         drain();
         check("roundtrip_captured", 64'(cap_q.size()), 64'd8);
         for (int i = 0; i < cap_q.size() && i < 8; i++)
            send_beat(2'b10, cap_q[i], orig[i], tg[i], 1'b1);
         drain();
      end

      // Stream of 8 beats with out_ready low for cycles 3..7.
      for (int i = 0; i < 8; i++) begin
         orig[i] = {$urandom, $urandom};
         tg[i]   = TW'(i);
         md4[i]  = 2'($urandom);
      end
      b4 = 0;
      for (int cyc = 0; cyc < 60 && b4 < 8; cyc++) begin
         ordy = !(cyc >= 3 && cyc < 8);
         if (cyc == 7) begin
            check("stall_in_ready", 64'(in_ready), 64'd0);
            check("stall_occupancy", 64'(occupancy), 64'(PS));
         end
         drive(1'b1, md4[b4], orig[b4], model(md4[b4], orig[b4]), tg[b4], ordy, acc);
         if (acc) b4++;
      end
      check("stream_all_accepted", 64'(b4), 64'd8);
      drain();

      // out_ready toggling every cycle under continuous input.
      for (int cyc = 0; cyc < 80; cyc++) begin
         orig[0] = {$urandom, $urandom};
         md4[0]  = 2'($urandom);
         tg[0]   = TW'($urandom);
         drive(1'b1, md4[0], orig[0], model(md4[0], orig[0]), tg[0], cyc[0], acc);
      end
      drain();
      check("accepted_eq_emitted", 64'(n_acc), 64'(n_emit));
      check("occupancy_bounded", 64'(max_occ <= PS), 64'd1);

      // Reset with beats in flight on 1-, 2- and 4-stage instances.
      reset_test(0, 1);
      reset_test(1, 2);
      reset_test(2, 4);

      check("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
